// File: rtl/bcd_convert_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, default sizing and active-low 7-segment patterns.
package bcd_convert_seq_pkg;

    localparam int unsigned IN_W_DEF   = 7;
    localparam int unsigned DIGITS_DEF = 3;
    localparam int unsigned SEG_W      = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, a lit segment drives 0 (common anode)
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    function automatic logic [SEG_W-1:0] seg_pattern(input logic [3:0] nib);
        logic [SEG_W-1:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_convert_seq_seg7.sv
// Single-digit BCD to active-low 7-segment decoder (combinational).
// Only built when SEG_DECODE_EN is defined; non-BCD codes show blank.
`ifdef SEG_DECODE_EN
module seg7_decode
    import bcd_convert_seq_pkg::*;
(
    input  logic [3:0]       i_nib,
    output logic [SEG_W-1:0] o_seg_c
);

    assign o_seg_c = seg_pattern(i_nib);

endmodule
`endif

// File: rtl/bcd_convert_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// valid/ready on both sides. Define SEG_DECODE_EN to add the registered o_seg output.
module bcd_convert_seq
    import bcd_convert_seq_pkg::*;
#(
    parameter int unsigned IN_W   = IN_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    output logic                o_in_ready,
    input  logic [IN_W-1:0]     i_bin,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [4*DIGITS-1:0] o_bcd,
    output logic                o_busy
`ifdef SEG_DECODE_EN
    ,
    output logic [SEG_W*DIGITS-1:0] o_seg
`endif
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned WORK_W = IN_W + BCD_W;
    localparam int unsigned CNT_W  = $clog2(IN_W + 1);

    if ((10 ** DIGITS) < (2 ** IN_W)) begin : g_bad_digits
        $error("bcd_convert_seq: DIGITS too small to hold 2**IN_W-1");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WORK_W-1:0]  r_work;
    logic [WORK_W-1:0]  w_work_nxt;
    logic [WORK_W-1:0]  w_work_shift;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BCD_W-1:0]   w_bcd_done;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_last_shift;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_in_ready;
    logic               w_in_ready_nxt;
    logic               r_busy;
    logic               w_busy_nxt;

    // Add-3 correction on every BCD nibble that would overflow when doubled
    always_comb begin
        w_bcd_adj = '0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            logic [3:0] nib;
            nib = r_work[IN_W + 4*d +: 4];
            w_bcd_adj[4*d +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
    end

    always_comb begin
        w_work_shift = {w_bcd_adj, r_work[IN_W-1:0]} << 1;
        w_bcd_done   = w_work_shift[WORK_W-1 -: BCD_W];
        w_last_shift = (r_cnt == CNT_W'(1));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_valid)      w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last_shift) w_state_nxt = ST_DONE;
            ST_DONE:  if (i_ready)      w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef SEG_DECODE_EN
    logic [SEG_W*DIGITS-1:0] w_seg_raw;
    logic [SEG_W*DIGITS-1:0] w_seg_dec;
    logic [SEG_W*DIGITS-1:0] w_seg_nxt;
    logic [SEG_W*DIGITS-1:0] r_seg;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_seg
        seg7_decode u_dec (
            .i_nib   (w_bcd_done[4*g +: 4]),
            .o_seg_c (w_seg_raw[SEG_W*g +: SEG_W])
        );
    end

    // Blank zero digits above the most significant nonzero digit; units always shown
    always_comb begin
        logic lead;
        lead      = 1'b1;
        w_seg_dec = '0;
        for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
            if ((w_bcd_done[4*d +: 4] != 4'd0) || (d == 0)) begin
                lead = 1'b0;
            end
            w_seg_dec[SEG_W*d +: SEG_W] = lead ? SEG_BLANK : w_seg_raw[SEG_W*d +: SEG_W];
        end
    end
`endif

    // Output / datapath next-value logic
    always_comb begin
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        w_bcd_nxt   = r_bcd;
        w_valid_nxt = r_valid;
`ifdef SEG_DECODE_EN
        w_seg_nxt   = r_seg;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_work_nxt = {BCD_W'(0), i_bin};
                    w_cnt_nxt  = CNT_W'(IN_W);
                end
            end
            ST_SHIFT: begin
                w_work_nxt = w_work_shift;
                w_cnt_nxt  = r_cnt - CNT_W'(1);
                if (w_last_shift) begin
                    w_bcd_nxt   = w_bcd_done;
                    w_valid_nxt = 1'b1;
`ifdef SEG_DECODE_EN
                    w_seg_nxt   = w_seg_dec;
`endif
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
            end
        endcase
        w_in_ready_nxt = (w_state_nxt == ST_IDLE);
        w_busy_nxt     = (w_state_nxt == ST_SHIFT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work     <= '0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_work     <= w_work_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bcd      <= w_bcd_nxt;
            r_valid    <= w_valid_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

`ifdef SEG_DECODE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= {DIGITS{SEG_BLANK}};
        end else begin
            r_seg <= w_seg_nxt;
        end
    end

    assign o_seg = r_seg;
`endif

    assign o_in_ready = r_in_ready;
    assign o_valid    = r_valid;
    assign o_bcd      = r_bcd;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq: directed cases plus a randomly
// stalled 0..127 sweep scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_bcd_convert_seq;

    localparam int IN_W   = 7;
    localparam int DIGITS = 3;

    logic                clk;
    logic                reset;
    logic                i_valid;
    logic                o_in_ready;
    logic [IN_W-1:0]     i_bin;
    logic                o_valid;
    logic                i_ready;
    logic [4*DIGITS-1:0] o_bcd;
    logic                o_busy;
`ifdef SEG_DECODE_EN
    logic [7*DIGITS-1:0] o_seg;
`endif

    bcd_convert_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .o_in_ready (o_in_ready),
        .i_bin      (i_bin),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_bcd      (o_bcd),
        .o_busy     (o_busy)
`ifdef SEG_DECODE_EN
        ,
        .o_seg      (o_seg)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [20:0] seg_of(input int v);
        logic [6:0]  tab [10];
        logic [20:0] r;
        int          p;
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        p   = 1;
        r   = '0;
        for (int d = 0; d < 3; d++) begin
            r[7*d +: 7] = (d > 0 && v < p) ? 7'h7F : tab[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    // Reference model: a conversion takes IN_W cycles, the result holds until taken
    int          m_phase = 0;   // 0 waiting for input, 1 converting, 2 holding result
    int          m_left  = 0;
    int          m_val   = 0;
    logic [11:0] m_bcd   = '0;
    logic        m_valid = 1'b0;
    logic [20:0] m_seg   = {3{7'h7F}};

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_phase = 0; m_left = 0; m_val = 0;
            m_bcd = '0; m_valid = 1'b0; m_seg = {3{7'h7F}};
        end else begin
            case (m_phase)
                0: if (i_valid) begin
                       m_val = int'(i_bin); m_left = IN_W; m_phase = 1;
                   end
                1: begin
                       m_left--;
                       if (m_left == 0) begin
                           m_bcd = to_bcd(m_val); m_seg = seg_of(m_val);
                           m_valid = 1'b1; m_phase = 2;
                       end
                   end
                default: if (i_ready) begin
                       m_valid = 1'b0; m_phase = 0;
                   end
            endcase
        end
    end

    // Cycle-by-cycle compare against the model
    logic chk_en = 1'b0;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("m_valid",    32'(o_valid),    32'(m_valid));
            chk("m_in_ready", 32'(o_in_ready), 32'(m_phase == 0));
            chk("m_busy",     32'(o_busy),     32'(m_phase == 1));
            chk("m_bcd",      32'(o_bcd),      32'(m_bcd));
`ifdef SEG_DECODE_EN
            chk("m_seg",      32'(o_seg),      32'(m_seg));
`endif
        end
    end

    // In-order scoreboard for the sweep: one entry per completed result
    int   sent[$];
    logic sb_on  = 1'b0;
    logic prev_v = 1'b0;
    int   n_done = 0;
    initial forever begin
        @(negedge clk);
        if (sb_on && o_valid && !prev_v) begin
            chk("sb_order", 32'(o_bcd), (sent.size() > 0) ? 32'(to_bcd(sent.pop_front())) : 32'hFFF);
            n_done++;
        end
        prev_v = o_valid;
    end

    task automatic wait_ready();
        int g = 0;
        while (!o_in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("ready_timeout", 32'(o_in_ready), 32'd1);
    endtask

    task automatic start(input int v);
        i_valid = 1'b1;
        i_bin   = 7'(v);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("valid_timeout", 32'(o_valid), 32'd1);
    endtask

    task automatic run_one(input int v, input logic [11:0] exp, input string nm);
        int lat;
        wait_ready();
        start(v);
        wait_valid(lat);
        chk(nm, 32'(o_bcd), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        int  guard;
        logic acc;
        logic sweep_done;
        reset   = 1'b1;
        i_valid = 1'b0;
        i_bin   = '0;
        i_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(o_in_ready), 32'd1);
        chk("rst_valid",    32'(o_valid),    32'd0);
        chk("rst_busy",     32'(o_busy),     32'd0);
        chk("rst_bcd",      32'(o_bcd),      32'h000);
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Latency and first result
        start(99);
        chk("busy_after_accept", 32'(o_busy), 32'd1);
        wait_valid(lat);
        chk("latency_99", 32'(lat), 32'd7);
        chk("bcd_99", 32'(o_bcd), 32'h099);
        @(negedge clk);
        chk("valid_dropped", 32'(o_valid), 32'd0);

        run_one(0,   12'h000, "bcd_0");
        run_one(127, 12'h127, "bcd_127");
        run_one(100, 12'h100, "bcd_100");

        // Back-pressure in DONE, new input must be ignored
        i_ready = 1'b0;
        wait_ready();
        start(88);
        wait_valid(lat);
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_bin   = 7'd55;
            @(negedge clk);
            chk("stall_valid",    32'(o_valid),    32'd1);
            chk("stall_bcd",      32'(o_bcd),      32'h088);
            chk("stall_in_ready", 32'(o_in_ready), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        chk("stall_release", 32'(o_valid), 32'd0);
        @(negedge clk);
        chk("no_capture_55", 32'(o_busy), 32'd0);
        chk("no_capture_bcd", 32'(o_bcd), 32'h088);

        // Asynchronous reset in the middle of a conversion
        start(77);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_busy",  32'(o_busy),  32'd0);
        chk("arst_bcd",   32'(o_bcd),   32'h000);
        @(negedge clk);
        reset = 1'b0;
        chk("arst_in_ready", 32'(o_in_ready), 32'd1);
        run_one(42, 12'h042, "bcd_42");
`ifdef SEG_DECODE_EN
        chk("seg_42", 32'(o_seg), 32'({7'h7F, 7'h19, 7'h24}));
        run_one(0, 12'h000, "bcd_0_seg");
        chk("seg_0", 32'(o_seg), 32'({7'h7F, 7'h7F, 7'h40}));
`endif

        // Back-to-back sweep with random downstream stalls
        sweep_done = 1'b0;
        sb_on      = 1'b1;
        fork
            begin
                for (int v = 0; v < 128; v++) begin
                    i_valid = 1'b1;
                    i_bin   = 7'(v);
                    guard   = 0;
                    do begin
                        acc = o_in_ready;
                        @(negedge clk);
                        guard++;
                    end while (!acc && guard < 200);
                    if (acc) sent.push_back(v);
                    else chk("sweep_accept_timeout", 32'(v), 32'hFFFF);
                end
                i_valid = 1'b0;
                guard = 0;
                while (n_done < 128 && guard < 2000) begin
                    @(negedge clk);
                    guard++;
                end
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    i_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                end
                i_ready = 1'b1;
            end
        join
        chk("sweep_count", 32'(n_done), 32'd128);
        chk("sweep_left",  32'(sent.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
